sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single off-chip 16-bit SRAM between two requesters: the draw engine's pixel-fetch read port and a NIOS-side write port that uploads sprite and level tiles. It sits between those requesters and the SRAM_* pins, sequences every access, and owns the data-bus turnaround. Reads win during active video, and writes win during blanking. A starvation counter guarantees bounded write latency.

## Interface
- WR_MAX_WAIT, 64: cycles a pending write may lose arbitration before it is forced ahead of reads (range 1..255)
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- blank_n  in  1  high during active video (VGA_BLANK_N domain-aligned)
- rd_req  in  1  read request; hold with stable rd_addr until rd_ack
- rd_addr  in  20  read word address
- rd_ack  out  1  one-cycle pulse: read issued this cycle
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  16  read data, held until next rd_valid
- wr_req  in  1  write request; hold with stable wr_addr/wr_data/wr_be until wr_ack
- wr_addr  in  20  write word address
- wr_data  in  16  write data
- wr_be  in  2  byte enables {UB, LB}, active-high
- wr_ack  out  1  one-cycle pulse: write issued this cycle
- stat_rd_cnt  out  16  read grant count (see Configuration)
- stat_wr_cnt  out  16  write grant count (see Configuration)
- SRAM_ADDR  out  20  SRAM address, registered
- SRAM_DATA  inout  16  SRAM data bus; driven only in WR and WR_REC
- SRAM_CE, SRAM_OE, SRAM_WE, SRAM_UB, SRAM_LB  out  1 each  active-low, registered

## Operation
- FSM states:
  - IDLE: no access.
  - RD: OE=0, WE=1, UB=LB=0.
  - WR: OE=1, WE=0, UB/LB=~wr_be, data driven.
  - WR_REC: OE=1, WE=1, data still driven.
- Arbitration runs in IDLE, RD and WR_REC.
  - Write wins if wr_req and (blank_n==0 or wait_cnt>=WR_MAX_WAIT).
  - Otherwise read wins if rd_req.
  - Otherwise write wins if wr_req.
  - Otherwise go to IDLE.
- From WR, the FSM always goes to WR_REC. There is no arbitration in WR.
- From WR_REC, the next state may be WR or IDLE, but not RD: the state passes through IDLE for one cycle to float the bus before OE falls.
- wait_cnt (8-bit, saturating) increments each cycle wr_req is high and not granted. It clears on wr_ack.
- Transitions:
  - RD→RD is back-to-back: one read per cycle.
  - RD→WR is direct.
- In IDLE, SRAM_CE=1 and OE=WE=UB=LB=1. In every other state, SRAM_CE=0.
- Simultaneous rd_req and wr_req in active video with wait_cnt<WR_MAX_WAIT: the read is granted and wait_cnt increments.
- A request dropped before ack is never issued and produces no ack.

## Timing
- Outputs after reset:
  - SRAM_ADDR=0.
  - All SRAM controls =1.
  - SRAM_DATA=Z.
  - rd_ack=wr_ack=rd_valid=0, rd_data=0.
  - Stat counters =0.
  - wait_cnt=0, state IDLE.
- Reset_n assertion mid-write deasserts SRAM_WE immediately (asynchronous) and aborts the write with no ack.
- Read latency:
  - rd_req is sampled at edge N.
  - RD is active in cycle N..N+1, with rd_ack high and SRAM_ADDR=rd_addr.
  - Data is captured at edge N+1.
  - rd_valid is high in cycle N+1..N+2.
- Write:
  - wr_req is sampled at edge N.
  - WR is active in cycle N..N+1, with wr_ack high.
  - WR_REC follows in N+1..N+2.
  - Total bus occupancy is 2 cycles.
  - A read requested at edge N+1 issues no earlier than edge N+3.
- Sustained throughput: reads 1 per cycle; writes 1 per 2 cycles.
- Worst-case write latency in active video is WR_MAX_WAIT+1 cycles.

## Configuration
- SRAM_ARB_STATS_EN defined:
  - stat_rd_cnt and stat_wr_cnt increment on rd_ack and wr_ack respectively.
  - Both wrap modulo 2^16 (0xFFFF→0x0000).
  - Both clear on reset.
- SRAM_ARB_STATS_EN undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset released, no requests:
  - SRAM_CE/OE/WE=1 and SRAM_DATA=Z for 10 cycles.
  - No ack pulses.
- blank_n=1, rd_req held 4 cycles with addresses 0x00010..0x00013, SRAM model returns addr[15:0]:
  - 4 consecutive rd_ack pulses.
  - rd_valid one cycle later each, with data 0x0010..0x0013.
- blank_n=0, rd_req and wr_req both high at the same edge, wr_addr=0x00200, wr_data=0xBEEF, wr_be=2'b11:
  - wr_ack first.
  - WE low for exactly 1 cycle.
  - WR_REC, then IDLE.
  - rd_ack at the 4th cycle.
  - A readback of 0x00200 returns 0xBEEF.
- blank_n=1, rd_req held continuously, wr_req asserted, WR_MAX_WAIT=64:
  - wr_ack on the 65th cycle after wr_req.
  - Reads resume after WR_REC+IDLE.
- wr_be=2'b01 write of 0x1234 over existing 0xFFFF:
  - SRAM_UB=1, SRAM_LB=0 during WR.
  - Readback gives 0xFF34.
- Reset_n pulled low during WR cycle:
  - SRAM_WE returns high within the same cycle.
  - No wr_ack.
  - With SRAM_ARB_STATS_EN defined, stat_wr_cnt reads 0 afterwards.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 16-bit SRAM between a read port
// (draw-engine pixel fetch) and a write port (NIOS tile upload).
// Reads win during active video, and writes win during blanking. A saturating
// wait counter forces a starved write ahead of reads after WR_MAX_WAIT losses.
//
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   blank_n                 high during active video
//   rd_req/rd_addr          read request, held until rd_ack is observed
//   rd_ack, rd_valid        one-cycle pulses: read issued / rd_data valid
//   rd_data                 read data, held until next rd_valid
//   wr_req/wr_addr/wr_data/wr_be  write request, held until wr_ack
//   wr_ack                  one-cycle pulse: write issued
//   stat_rd_cnt/stat_wr_cnt grant counters (0 unless SRAM_ARB_STATS_EN)
//   SRAM_*                  registered SRAM pins; SRAM_DATA driven in WR/WR_REC
//
// Build option: define SRAM_ARB_STATS_EN to build the grant counters.

module sram_arbiter #(
    parameter int unsigned WR_MAX_WAIT = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        blank_n,
    input  logic        rd_req,
    input  logic [19:0] rd_addr,
    output logic        rd_ack,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    input  logic        wr_req,
    input  logic [19:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_be,
    output logic        wr_ack,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DATA,
    output logic        SRAM_CE,
    output logic        SRAM_OE,
    output logic        SRAM_WE,
    output logic        SRAM_UB,
    output logic        SRAM_LB
);

    localparam logic [7:0] WrMaxWait = 8'(WR_MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StWrRec} state_e;

    state_e      r_state;
    state_e      w_next;
    logic        w_rd_grant;
    logic        w_wr_grant;
    logic        w_wr_urgent;
    logic [7:0]  r_wait_cnt;
    logic        r_rd_ack;
    logic        r_wr_ack;
    logic        r_rd_valid;
    logic [15:0] r_rd_data;
    logic [19:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_drive;
    logic        r_ce;
    logic        r_oe;
    logic        r_we;
    logic        r_ub;
    logic        r_lb;

    assign w_wr_urgent = wr_req && (!blank_n || (r_wait_cnt >= WrMaxWait));

    // Arbitration; WR never arbitrates, and WR_REC cannot go straight to RD
    // because the bus needs an idle cycle to float before OE falls.
    always_comb begin
        w_next     = StIdle;
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        if (r_state == StWr) begin
            w_next = StWrRec;
        end else if (w_wr_urgent) begin
            w_next     = StWr;
            w_wr_grant = 1'b1;
        end else if (rd_req) begin
            if (r_state != StWrRec) begin
                w_next     = StRd;
                w_rd_grant = 1'b1;
            end
        end else if (wr_req) begin
            w_next     = StWr;
            w_wr_grant = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= StIdle;
            r_wait_cnt <= 8'd0;
            r_rd_ack   <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 16'd0;
            r_addr     <= 20'd0;
            r_wdata    <= 16'd0;
            r_drive    <= 1'b0;
            r_ce       <= 1'b1;
            r_oe       <= 1'b1;
            r_we       <= 1'b1;
            r_ub       <= 1'b1;
            r_lb       <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_rd_ack   <= w_rd_grant;
            r_wr_ack   <= w_wr_grant;
            r_rd_valid <= (r_state == StRd);
            if (r_state == StRd) begin
                r_rd_data <= SRAM_DATA;
            end

            if (w_wr_grant) begin
                r_wait_cnt <= 8'd0;
            end else if (wr_req && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // Pin controls are registered from the next state so they line up
            // with the state that owns the bus.
            case (w_next)
                StRd: begin
                    r_addr  <= rd_addr;
                    r_drive <= 1'b0;
                    r_ce    <= 1'b0;
                    r_oe    <= 1'b0;
                    r_we    <= 1'b1;
                    r_ub    <= 1'b0;
                    r_lb    <= 1'b0;
                end
                StWr: begin
                    r_addr  <= wr_addr;
                    r_wdata <= wr_data;
                    r_drive <= 1'b1;
                    r_ce    <= 1'b0;
                    r_oe    <= 1'b1;
                    r_we    <= 1'b0;
                    r_ub    <= ~wr_be[1];
                    r_lb    <= ~wr_be[0];
                end
                StWrRec: begin
                    // Keep address, data and byte lanes stable for hold time.
                    r_drive <= 1'b1;
                    r_ce    <= 1'b0;
                    r_oe    <= 1'b1;
                    r_we    <= 1'b1;
                end
                default: begin
                    r_drive <= 1'b0;
                    r_ce    <= 1'b1;
                    r_oe    <= 1'b1;
                    r_we    <= 1'b1;
                    r_ub    <= 1'b1;
                    r_lb    <= 1'b1;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stat_rd <= 16'd0;
            r_stat_wr <= 16'd0;
        end else begin
            if (w_rd_grant) r_stat_rd <= r_stat_rd + 16'd1;
            if (w_wr_grant) r_stat_wr <= r_stat_wr + 16'd1;
        end
    end

    assign stat_rd_cnt = r_stat_rd;
    assign stat_wr_cnt = r_stat_wr;
`else
    assign stat_rd_cnt = 16'd0;
    assign stat_wr_cnt = 16'd0;
`endif

    assign rd_ack    = r_rd_ack;
    assign wr_ack    = r_wr_ack;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign SRAM_ADDR = r_addr;
    assign SRAM_DATA = r_drive ? r_wdata : 16'hzzzz;
    assign SRAM_CE   = r_ce;
    assign SRAM_OE   = r_oe;
    assign SRAM_WE   = r_we;
    assign SRAM_UB   = r_ub;
    assign SRAM_LB   = r_lb;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM model.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        blank_n = 1'b1;
    logic        rd_req = 1'b0;
    logic [19:0] rd_addr = 20'd0;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_req = 1'b0;
    logic [19:0] wr_addr = 20'd0;
    logic [15:0] wr_data = 16'd0;
    logic [1:0]  wr_be = 2'b00;
    logic        wr_ack;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
    logic [19:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_ce, sram_oe, sram_we, sram_ub, sram_lb;

    int n_checks = 0;
    int n_errors = 0;

    always #10 Clk = ~Clk;

    sram_arbiter #(.WR_MAX_WAIT(64)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .blank_n     (blank_n),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .wr_ack      (wr_ack),
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt),
        .SRAM_ADDR   (sram_addr),
        .SRAM_DATA   (sram_data),
        .SRAM_CE     (sram_ce),
        .SRAM_OE     (sram_oe),
        .SRAM_WE     (sram_we),
        .SRAM_UB     (sram_ub),
        .SRAM_LB     (sram_lb)
    );

    // SRAM model: 1K words, each word initialised to its own address.
    logic [15:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

    assign sram_data = (!sram_ce && !sram_oe && sram_we) ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge Clk) begin
        if (!sram_ce && !sram_we) begin
            if (!sram_ub) mem[sram_addr[9:0]][15:8] <= sram_data[15:8];
            if (!sram_lb) mem[sram_addr[9:0]][7:0]  <= sram_data[7:0];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [4:0] ctrl();
        return {sram_ce, sram_oe, sram_we, sram_ub, sram_lb};
    endfunction

    int k;
    int n_rd;

    initial begin
        // Reset state
        repeat (2) tick();
        check_eq("rst_ctrl", 32'(ctrl()), 32'h1F);
        check_eq("rst_addr", 32'(sram_addr), 32'h0);
        check_eq("rst_acks", 32'({rd_ack, wr_ack, rd_valid}), 32'h0);
        check_eq("rst_rd_data", 32'(rd_data), 32'h0);
        check_eq("rst_drive", 32'(dut.r_drive), 32'h0);
        check_eq("rst_stats", {stat_rd_cnt, stat_wr_cnt}, 32'h0);
        Reset_n = 1'b1;

        // Idle after reset for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_ctrl", 32'(ctrl()), 32'h1F);
            check_eq("idle_acks", 32'({rd_ack, wr_ack}), 32'h0);
            check_eq("idle_drive", 32'(dut.r_drive), 32'h0);
        end

        // Back-to-back reads in active video
        blank_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = 20'h00010 + 20'(i);
            tick();
            check_eq("b2b_rd_ack", 32'(rd_ack), 32'h1);
            check_eq("b2b_rd_addr", 32'(sram_addr), 32'h10 + 32'(i));
            check_eq("b2b_oe", 32'(sram_oe), 32'h0);
            if (i > 0) begin
                check_eq("b2b_valid", 32'(rd_valid), 32'h1);
                check_eq("b2b_data", 32'(rd_data), 32'h10 + 32'(i) - 32'h1);
            end
        end
        rd_req = 1'b0;
        tick();
        check_eq("b2b_valid_last", 32'(rd_valid), 32'h1);
        check_eq("b2b_data_last", 32'(rd_data), 32'h13);
        check_eq("b2b_no_ack", 32'(rd_ack), 32'h0);

        // Blanking: write beats a simultaneous read, then read back
        blank_n = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 20'h00200;
        wr_req  = 1'b1;
        wr_addr = 20'h00200;
        wr_data = 16'hBEEF;
        wr_be   = 2'b11;
        tick();
        check_eq("blk_wr_ack", 32'({wr_ack, rd_ack}), 32'h2);
        check_eq("blk_we_low", 32'(sram_we), 32'h0);
        wr_req = 1'b0;
        tick();
        check_eq("blk_wrrec", 32'({sram_ce, sram_oe, sram_we, wr_ack, rd_ack}), 32'h0C);
        tick();
        check_eq("blk_idle", 32'({sram_ce, rd_ack}), 32'h2);
        tick();
        check_eq("blk_rd_ack4", 32'(rd_ack), 32'h1);
        check_eq("blk_rd_addr", 32'(sram_addr), 32'h200);
        rd_req = 1'b0;
        tick();
        check_eq("blk_readback", 32'({rd_valid, rd_data}), 32'h1BEEF);

        // Active video: continuous reads starve a write until WR_MAX_WAIT
        blank_n = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 20'h00050;
        tick();
        wr_req  = 1'b1;
        wr_addr = 20'h00300;
        wr_data = 16'hFFFF;
        wr_be   = 2'b11;
        k = 0;
        n_rd = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (wr_ack) begin
                k = i;
                break;
            end
            if (rd_ack) n_rd++;
        end
        wr_req = 1'b0;
        check_eq("starve_wr_cycle", 32'(k), 32'd65);
        check_eq("starve_reads", 32'(n_rd), 32'd64);
        check_eq("starve_no_rd", 32'(rd_ack), 32'h0);
        tick();
        check_eq("starve_wrrec", 32'({rd_ack, sram_we, sram_oe}), 32'h3);
        tick();
        check_eq("starve_idle", 32'({rd_ack, sram_ce}), 32'h1);
        tick();
        check_eq("starve_resume", 32'(rd_ack), 32'h1);
        rd_req = 1'b0;
        tick();

        // Byte-lane write: lower byte only over 0xFFFF
        blank_n = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 20'h00300;
        wr_data = 16'h1234;
        wr_be   = 2'b01;
        tick();
        check_eq("be_ack", 32'(wr_ack), 32'h1);
        check_eq("be_lanes", 32'({sram_we, sram_ub, sram_lb}), 32'h2);
        wr_req = 1'b0;
        tick();
        tick();
        rd_req  = 1'b1;
        rd_addr = 20'h00300;
        tick();
        check_eq("be_rd_ack", 32'(rd_ack), 32'h1);
        rd_req = 1'b0;
        tick();
        check_eq("be_readback", 32'({rd_valid, rd_data}), 32'h1FF34);
        tick();

`ifdef SRAM_ARB_STATS_EN
        check_eq("stat_rd", 32'(stat_rd_cnt), 32'd72);
        check_eq("stat_wr", 32'(stat_wr_cnt), 32'd3);
`else
        check_eq("stat_off", {stat_rd_cnt, stat_wr_cnt}, 32'h0);
`endif

        // Reset asserted mid-write
        wr_req  = 1'b1;
        wr_addr = 20'h00301;
        wr_data = 16'hAAAA;
        wr_be   = 2'b11;
        tick();
        check_eq("abort_pre_we", 32'({wr_ack, sram_we}), 32'h2);
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("abort_we_high", 32'(sram_we), 32'h1);
        check_eq("abort_no_ack", 32'(wr_ack), 32'h0);
        check_eq("abort_ce_high", 32'(sram_ce), 32'h1);
        check_eq("abort_stat_wr", 32'(stat_wr_cnt), 32'h0);
        wr_req = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        check_eq("post_rst_idle", 32'({ctrl(), rd_ack, wr_ack}), 32'h7C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
